// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the display blocks.
// Glyphs are active-low, bit 0 = segment a, bit 6 = segment g.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Per-slot scan phase: anodes off (GAP) then digit driven (SHOW).
    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } scan_state_e;

endpackage

// File: rtl/hexto7segment.sv
// Hex nibble to active-low seven-segment glyph decoder.
// Purely combinational; glyph table lives in seg7_pkg.
module hexto7segment
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Nibble to glyph lookup
    always_comb begin
        seg = SEG_BLANK;
        unique case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous
// double-buffered data, per-slot anode blanking and leading-zero blanking.
module display_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              lz_en,
    output logic              pending,
    output logic [6:0]        hex,
    output logic              dp,
    output logic [NDIG-1:0]   an
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    scan_state_e       state_q, state_d;

    logic [4*NDIG-1:0] act_val_q, act_val_d;
    logic [NDIG-1:0]   act_dp_q, act_dp_d;
    logic [4*NDIG-1:0] pnd_val_q, pnd_val_d;
    logic [NDIG-1:0]   pnd_dp_q, pnd_dp_d;
    logic              pending_q, pending_d;

    logic [6:0]        hex_q, hex_d;
    logic              dp_q, dp_d;
    logic [NDIG-1:0]   an_q, an_d;

    logic              slot_end;
    logic              frame_end;
    logic [3:0]        nib;
    logic              dig_dp;
    logic              dark;
    logic              hi_zero;
    logic [6:0]        seg;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // Slot counter, digit index and GAP/SHOW phase
    always_comb begin
        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        state_d = state_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        unique case (state_q)
            ST_GAP:  if (cnt_d == CNT_SHOW) state_d = ST_SHOW;
            ST_SHOW: if (slot_end) state_d = ST_GAP;
        endcase
    end

    // Pending/active double buffer: swap only at frame boundary so a
    // frame is never drawn with mixed old and new digits
    always_comb begin
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        pnd_val_d = pnd_val_q;
        pnd_dp_d  = pnd_dp_q;
        pending_d = pending_q;
        if (frame_end && pending_q) begin
            act_val_d = pnd_val_q;
            act_dp_d  = pnd_dp_q;
            pending_d = 1'b0;
        end
        if (load) begin
            pnd_val_d = value;
            pnd_dp_d  = dp_in;
            pending_d = 1'b1;
        end
    end

    // Select active nibble for idx and decide leading-zero blanking
    always_comb begin
        nib     = 4'h0;
        dig_dp  = 1'b0;
        dark    = 1'b0;
        hi_zero = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            hi_zero = hi_zero && (act_val_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                nib    = act_val_q[4*i +: 4];
                dig_dp = act_dp_q[i];
                dark   = lz_en && (i != 0) && hi_zero;
            end
        end
    end

    hexto7segment u_dec (
        .nib (nib),
        .seg (seg)
    );

    // Next pin values; registered below for glitch-free outputs
    always_comb begin
        an_d  = '1;
        hex_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (state_q == ST_SHOW && !dark) begin
            an_d[idx_q] = 1'b0;
            hex_d       = seg;
            dp_d        = ~dig_dp;
        end
    end

    // Scan FSM, data buffers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            state_q   <= ST_GAP;
            act_val_q <= '0;
            act_dp_q  <= '0;
            pnd_val_q <= '0;
            pnd_dp_q  <= '0;
            pending_q <= 1'b0;
            hex_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            an_q      <= '1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            pnd_val_q <= pnd_val_d;
            pnd_dp_q  <= pnd_dp_d;
            pending_q <= pending_d;
            hex_q     <= hex_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign pending = pending_q;
    assign hex     = hex_q;
    assign dp      = dp_q;
    assign an      = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl (NDIG=4, DIV=8, BLANK=2).
// k counts negedges since reset release; pins at k reflect scan cycle k-1.
module tb_display_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic        pending;
    logic [6:0]  hex;
    logic        dp;
    logic [3:0]  an;

    int n_cmp;
    int n_bad;
    int k;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] hex;
        logic       dp;
    } pins_t;

    localparam pins_t DARK = '{an: 4'b1111, hex: 7'b1111111, dp: 1'b1};

    display_scan_ctrl #(
        .NDIG  (4),
        .DIV   (8),
        .BLANK (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .value   (value),
        .dp_in   (dp_in),
        .lz_en   (lz_en),
        .pending (pending),
        .hex     (hex),
        .dp      (dp),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, required $finish");
        $fatal(1);
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Expected pins at negedge kk given the data active during cycle kk-1
    function automatic pins_t exp_pins(input int kk, input logic [15:0] act,
                                       input logic [3:0] dpv, input logic lz);
        pins_t p;
        int c;
        int d;
        logic [15:0] s;
        p = DARK;
        if (kk < 1) return p;
        c = (kk - 1) % 8;
        d = ((kk - 1) / 8) % 4;
        if (c < 2) return p;
        s = act >> (4 * d);
        if (lz && d != 0 && s == 16'h0) return p;
        p.an  = ~(4'b0001 << d);
        p.hex = glyph(s[3:0]);
        p.dp  = ~dpv[d];
        return p;
    endfunction

    task automatic tick();
        @(negedge clk);
        k = k + 1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        dp_in = 4'h0;
        lz_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({an, hex, dp} !== DARK) begin
                n_bad++;
                $display("FAIL reset_pins cyc=%0d got an=%b hex=%b dp=%b required %b",
                         i, an, hex, dp, DARK);
            end
            n_cmp++;
            if (pending !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_pending cyc=%0d got %b required 0", i, pending);
            end
        end
        rst = 1'b0;
        k   = 0;
    endtask

    task automatic test_scan();
        pins_t e;
        while (k < 40) begin
            tick();
            e = exp_pins(k, 16'h0, 4'h0, 1'b0);
            n_cmp++;
            if ({an, hex, dp} !== e) begin
                n_bad++;
                $display("FAIL scan_pins k=%0d got an=%b hex=%b dp=%b required %b",
                         k, an, hex, dp, e);
            end
            n_cmp++;
            if ($countones(~an) > 1) begin
                n_bad++;
                $display("FAIL scan_onehot k=%0d got an=%b required <=1 low", k, an);
            end
        end
    endtask

    task automatic test_load();
        pins_t e;
        logic [15:0] a;
        logic [3:0] dv;
        logic ep;
        while (k < 69) begin
            load  = (k == 40);
            value = 16'h12AF;
            dp_in = 4'b0101;
            tick();
            a  = (k - 1 >= 64) ? 16'h12AF : 16'h0;
            dv = (k - 1 >= 64) ? 4'b0101 : 4'b0000;
            ep = (k >= 41 && k < 64);
            e  = exp_pins(k, a, dv, 1'b0);
            n_cmp++;
            if ({an, hex, dp} !== e) begin
                n_bad++;
                $display("FAIL load_pins k=%0d got an=%b hex=%b dp=%b required %b",
                         k, an, hex, dp, e);
            end
            n_cmp++;
            if (pending !== ep) begin
                n_bad++;
                $display("FAIL load_pending k=%0d got %b required %b", k, pending, ep);
            end
            n_cmp++;
            if ($countones(~an) > 1) begin
                n_bad++;
                $display("FAIL load_onehot k=%0d got an=%b required <=1 low", k, an);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_double_load();
        pins_t e;
        logic [15:0] a;
        logic [3:0] dv;
        logic ep;
        while (k < 99) begin
            load  = (k == 70) || (k == 80);
            value = (k == 70) ? 16'h1111 : 16'h2222;
            dp_in = (k == 70) ? 4'b1111 : 4'b0010;
            tick();
            a  = (k - 1 >= 96) ? 16'h2222 : 16'h12AF;
            dv = (k - 1 >= 96) ? 4'b0010 : 4'b0101;
            ep = (k >= 71 && k < 96);
            e  = exp_pins(k, a, dv, 1'b0);
            n_cmp++;
            if ({an, hex, dp} !== e) begin
                n_bad++;
                $display("FAIL dbl_pins k=%0d got an=%b hex=%b dp=%b required %b",
                         k, an, hex, dp, e);
            end
            n_cmp++;
            if (pending !== ep) begin
                n_bad++;
                $display("FAIL dbl_pending k=%0d got %b required %b", k, pending, ep);
            end
            n_cmp++;
            if ($countones(~an) > 1) begin
                n_bad++;
                $display("FAIL dbl_onehot k=%0d got an=%b required <=1 low", k, an);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_leading_zero();
        pins_t e;
        logic [15:0] a;
        logic [3:0] dv;
        logic ep;
        lz_en = 1'b1;
        while (k < 192) begin
            load  = (k == 100) || (k == 130);
            value = (k == 100) ? 16'h0050 : 16'h0000;
            dp_in = (k == 100) ? 4'b0100 : 4'b0001;
            tick();
            if (k - 1 < 128) begin
                a  = 16'h2222;
                dv = 4'b0010;
            end else if (k - 1 < 160) begin
                a  = 16'h0050;
                dv = 4'b0100;
            end else begin
                a  = 16'h0000;
                dv = 4'b0001;
            end
            ep = (k >= 101 && k < 128) || (k >= 131 && k < 160);
            e  = exp_pins(k, a, dv, 1'b1);
            n_cmp++;
            if ({an, hex, dp} !== e) begin
                n_bad++;
                $display("FAIL lz_pins k=%0d got an=%b hex=%b dp=%b required %b",
                         k, an, hex, dp, e);
            end
            n_cmp++;
            if (pending !== ep) begin
                n_bad++;
                $display("FAIL lz_pending k=%0d got %b required %b", k, pending, ep);
            end
            n_cmp++;
            if ($countones(~an) > 1) begin
                n_bad++;
                $display("FAIL lz_onehot k=%0d got an=%b required <=1 low", k, an);
            end
        end
        load  = 1'b0;
        lz_en = 1'b0;
    endtask

    task automatic test_boundary_load();
        pins_t e;
        logic [15:0] a;
        logic [3:0] dv;
        logic ep;
        while (k < 288) begin
            load  = (k == 200) || (k == 223);
            value = (k == 200) ? 16'h3456 : 16'h789A;
            dp_in = (k == 200) ? 4'b1000 : 4'b0001;
            tick();
            if (k - 1 < 224) begin
                a  = 16'h0000;
                dv = 4'b0001;
            end else if (k - 1 < 256) begin
                a  = 16'h3456;
                dv = 4'b1000;
            end else begin
                a  = 16'h789A;
                dv = 4'b0001;
            end
            ep = (k >= 201 && k < 256);
            e  = exp_pins(k, a, dv, 1'b0);
            n_cmp++;
            if ({an, hex, dp} !== e) begin
                n_bad++;
                $display("FAIL bnd_pins k=%0d got an=%b hex=%b dp=%b required %b",
                         k, an, hex, dp, e);
            end
            n_cmp++;
            if (pending !== ep) begin
                n_bad++;
                $display("FAIL bnd_pending k=%0d got %b required %b", k, pending, ep);
            end
            n_cmp++;
            if ($countones(~an) > 1) begin
                n_bad++;
                $display("FAIL bnd_onehot k=%0d got an=%b required <=1 low", k, an);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid();
        pins_t e;
        logic ep;
        while (k < 308) begin
            load  = (k == 290);
            value = 16'hABCD;
            dp_in = 4'b1111;
            tick();
            ep = (k >= 291);
            e  = exp_pins(k, 16'h789A, 4'b0001, 1'b0);
            n_cmp++;
            if ({an, hex, dp} !== e) begin
                n_bad++;
                $display("FAIL rmid_pins k=%0d got an=%b hex=%b dp=%b required %b",
                         k, an, hex, dp, e);
            end
            n_cmp++;
            if (pending !== ep) begin
                n_bad++;
                $display("FAIL rmid_pending k=%0d got %b required %b", k, pending, ep);
            end
        end
        rst   = 1'b1;
        load  = 1'b1;
        value = 16'h5555;
        dp_in = 4'b1111;
        tick();
        n_cmp++;
        if ({an, hex, dp} !== DARK) begin
            n_bad++;
            $display("FAIL rmid_dark got an=%b hex=%b dp=%b required %b",
                     an, hex, dp, DARK);
        end
        n_cmp++;
        if (pending !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_pend_clr got %b required 0", pending);
        end
        rst  = 1'b0;
        load = 1'b0;
        k    = 0;
        while (k < 36) begin
            tick();
            e = exp_pins(k, 16'h0000, 4'b0000, 1'b0);
            n_cmp++;
            if ({an, hex, dp} !== e) begin
                n_bad++;
                $display("FAIL rpost_pins k=%0d got an=%b hex=%b dp=%b required %b",
                         k, an, hex, dp, e);
            end
            n_cmp++;
            if (pending !== 1'b0) begin
                n_bad++;
                $display("FAIL rpost_pending k=%0d got %b required 0", k, pending);
            end
            n_cmp++;
            if ($countones(~an) > 1) begin
                n_bad++;
                $display("FAIL rpost_onehot k=%0d got an=%b required <=1 low", k, an);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        k     = 0;
        test_reset();
        test_scan();
        test_load();
        test_double_load();
        test_leading_zero();
        test_boundary_load();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
